cascade_sequencer: RTL and testbench
====================================

// Module: cascade_sequencer
// PURPOSE
//  Clocked, parametrised successor to the combinational cascade comparator.
//  Sequences the INTA pulse train, drives CAS lines as master, and matches CAS against the slave ID as slave.
//  Generates the per-pulse vector-read enable.
//  Sits between the priority resolver/ICW registers and the data-bus buffer.
//  Supports 8086 (2-pulse) and 8080 (3-pulse) modes, plus a pulse-gap timeout abort.
// PARAMETERS
//  CAS_W    3   cascade bus width; slave count NSLV = 2**CAS_W
//  TIMEOUT  15  max clk cycles inta_n may stay high between pulses before abort
// PORTS
//  clk         in   1       system clock, all logic on rising edge
//  rst         in   1       synchronous, active-high reset
//  inta_n      in   1       INTA, already synchronised to clk, active low
//  sp_en_n     in   1       1 = master, 0 = slave (used when buf_mode=0)
//  buf_mode    in   1       buffered mode; role then taken from buf_ms
//  buf_ms      in   1       buffered-mode role: 1 = master, 0 = slave
//  cfg_sngl    in   1       single mode: no cascade, CAS never driven
//  cfg_mode86  in   1       1 = 8086 (2 pulses), 0 = 8080 (3 pulses)
//  cfg_slv     in   NSLV    master ICW3: bit i set = slave on IR i
//  slave_id    in   CAS_W   slave ICW3 ID
//  ack_level   in   CAS_W   IR level granted by priority resolver
//  cas_in      in   CAS_W   CAS bus as seen on pins
//  cas_out     out  CAS_W   CAS value driven as master
//  cas_oe      out  1       CAS output enable
//  cas_match   out  1       slave: latched cas_in==slave_id
//  vec_rd_en   out  1       this device drives the data bus this pulse
//  byte_sel    out  2       0 = CALL opcode, 1 = vector low/8086 vector, 2 = vector high
//  seq_done    out  1       one-cycle pulse after the final INTA rising edge
//  seq_abort   out  1       one-cycle pulse on timeout
// BEHAVIOUR
//  - Role: master = buf_mode ? buf_ms : sp_en_n; sampled at 1st falling edge and held for the sequence.
//  - Edge detect: inta_q registered copy of inta_n.
//    - fall = inta_q & ~inta_n
//    - rise = ~inta_q & inta_n
//  - FSM: IDLE -> PULSE(k) on fall -> GAP(k) on rise -> PULSE(k+1) on fall.
//    - k counts 1..N, with N = cfg_mode86 ? 2 : 3.
//    - Rise in PULSE(N) -> DONE (1 cycle, seq_done=1) -> IDLE.
//  - Timeout: gap counter cleared on each fall and counts clk cycles in GAP.
//    - Reaching TIMEOUT -> seq_abort=1 for 1 cycle -> IDLE; all outputs cleared.
//  - Master cascade, entered at 1st fall: lvl<=ack_level; casc = ~cfg_sngl & cfg_slv[lvl].
//    - If casc: cas_out=lvl and cas_oe=1 from the cycle after 1st fall until the DONE cycle (inclusive).
//    - Otherwise cas_oe=0 and cas_out=0.
//  - Slave, entered at 1st fall (IDLE->PULSE(1) transition): cas_match <= (cas_in==slave_id).
//    - cas_match is held until IDLE.
//  - vec_rd_en, asserted only while inta_n low (in PULSE states), 1 cycle after fall:
//    - 8086: pulse 1 -> 0 for all devices.
//      - Pulse 2 -> 1 for a master with !casc, or for a slave with cas_match; byte_sel=1.
//    - 8080: pulse 1 -> 1 for a master only (CALL, byte_sel=0), casc or not.
//      - Pulses 2 and 3 -> master with !casc, or slave with cas_match; byte_sel=1 then 2.
//  - Fall while in DONE is ignored; the next sequence requires IDLE.
//  - cfg_* inputs are sampled only at the 1st fall; mid-sequence changes have no effect.
//  - Reset at the clock edge with rst=1, including mid-sequence:
//    - FSM=IDLE, counters=0.
//    - cas_out=0, cas_oe=0, cas_match=0, vec_rd_en=0, byte_sel=0, seq_done=0, seq_abort=0.
//  - Reset wins over simultaneous fall/rise/timeout.
// CONFIGURATION
//  CAS_PARITY_EN defined:
//    - Adds ports cas_par_out (out 1) and cas_par_in (in 1).
//    - Master drives even parity of cas_out, gated with cas_oe.
//    - Slave sets cas_match only if (cas_in==slave_id) & (^{cas_in,cas_par_in}==0).
//    - On parity fail the slave asserts no vec_rd_en and stays in sequence until DONE.
//  Not defined: no parity ports; matching on ID only.
// TESTING
//  1. Master, 8086, cfg_slv=8'h04, ack_level=2, two INTA pulses
//     -> cas_oe=1 with cas_out=3'd2 through DONE; vec_rd_en=0 both pulses; seq_done 1 cycle.
//  2. Slave, slave_id=5, cas_in=5, 8086 -> cas_match=1.
//     vec_rd_en=1, byte_sel=1 only during pulse 2. Same with cas_in=4 -> cas_match=0, vec_rd_en=0.
//  3. Master, 8080, cfg_slv=0, ack_level=6, three pulses
//     -> vec_rd_en on pulses 1, 2, 3 with byte_sel 0, 1, 2; cas_oe=0 throughout.
//  4. Master, 8086, inta_n high 16 cycles after pulse 1
//     -> seq_abort at cycle 15; outputs 0; next pulse starts a new sequence.
//  5. rst=1 during pulse 2 with cas_oe=1 -> all outputs 0 next edge; FSM IDLE.
//  6. buf_mode=1, buf_ms=0, sp_en_n=1 -> acts as slave.
//     With CAS_PARITY_EN, cas_in=5 and bad parity -> cas_match=0, vec_rd_en=0.

Source files
------------

// File: rtl/cascade_sequencer.sv
// cascade_sequencer
//   Clocked cascade/INTA sequencer for an 8259-style interrupt controller.
//   Tracks the INTA pulse train (2 pulses in 8086 mode, 3 in 8080 mode).
//   As master it drives the CAS bus with the granted IR level.
//   As slave it latches whether the CAS bus addresses this device.
//   It also tells the data-bus buffer which byte this device drives on each pulse.
//   A pulse-gap timeout aborts a stalled sequence.
//
// Parameters
//   CAS_W    cascade bus width; number of slaves is 2**CAS_W
//   TIMEOUT  max clk cycles inta_n may stay high between pulses before abort
//
// Ports
//   clk, rst     rising-edge clock, synchronous active-high reset
//   inta_n       INTA (already synchronised), active low
//   sp_en_n      role when not buffered: 1 = master, 0 = slave
//   buf_mode     buffered mode; role then comes from buf_ms
//   buf_ms       buffered-mode role: 1 = master, 0 = slave
//   cfg_sngl     single mode: no cascade, CAS never driven
//   cfg_mode86   1 = 8086 (2 pulses), 0 = 8080 (3 pulses)
//   cfg_slv      master ICW3: bit i set = slave on IR i
//   slave_id     slave ICW3 ID
//   ack_level    IR level granted by the priority resolver
//   cas_in       CAS bus as seen on the pins
//   cas_out      CAS value driven as master
//   cas_oe       CAS output enable
//   cas_match    slave: latched cas_in == slave_id
//   vec_rd_en    this device drives the data bus during this pulse
//   byte_sel     0 = CALL opcode, 1 = vector low / 8086 vector, 2 = vector high
//   seq_done     one-cycle pulse after the final INTA rising edge
//   seq_abort    one-cycle pulse on pulse-gap timeout
//
// Optional build macro CAS_PARITY_EN
//   Adds cas_par_out (even parity of cas_out, gated by cas_oe) and cas_par_in.
//   With the macro, a slave only matches when the CAS bus and its parity bit
//   together carry even parity.

module cascade_sequencer #(
  parameter int CAS_W   = 3,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inta_n,
  input  logic                sp_en_n,
  input  logic                buf_mode,
  input  logic                buf_ms,
  input  logic                cfg_sngl,
  input  logic                cfg_mode86,
  input  logic [2**CAS_W-1:0] cfg_slv,
  input  logic [CAS_W-1:0]    slave_id,
  input  logic [CAS_W-1:0]    ack_level,
  input  logic [CAS_W-1:0]    cas_in,
  output logic [CAS_W-1:0]    cas_out,
  output logic                cas_oe,
  output logic                cas_match,
  output logic                vec_rd_en,
  output logic [1:0]          byte_sel,
  output logic                seq_done,
  output logic                seq_abort
`ifdef CAS_PARITY_EN
  ,
  output logic                cas_par_out,
  input  logic                cas_par_in
`endif
);

  localparam int GW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PULSE,
    S_GAP,
    S_DONE,
    S_ABORT
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_k;
  logic [1:0]       w_k_nxt;
  logic [GW-1:0]    r_gap;
  logic [GW-1:0]    w_gap_nxt;
  logic             w_start;

  logic             r_inta_q;
  logic             r_master;
  logic             r_casc;
  logic             r_mode86;
  logic             r_cas_match;
  logic [CAS_W-1:0] r_lvl;

  logic             w_fall;
  logic             w_rise;
  logic             w_master;
  logic             w_casc;
  logic             w_id_ok;
  logic [1:0]       w_last_k;
  logic             w_active;
  logic             w_owner;

  assign w_fall   = r_inta_q & ~inta_n;
  assign w_rise   = ~r_inta_q & inta_n;
  assign w_master = buf_mode ? buf_ms : sp_en_n;
  assign w_casc   = ~cfg_sngl & cfg_slv[ack_level];

`ifdef CAS_PARITY_EN
  assign w_id_ok     = (cas_in == slave_id) & ~(^{cas_in, cas_par_in});
  assign cas_par_out = cas_oe & (^cas_out);
`else
  assign w_id_ok     = (cas_in == slave_id);
`endif

  // Mode is taken from the value latched at the first fall, not the live input.
  assign w_last_k = r_mode86 ? 2'd2 : 2'd3;
  assign w_active = (r_state == S_PULSE) || (r_state == S_GAP) || (r_state == S_DONE);
  // Device that owns the vector bytes: an uncascaded master, or the addressed slave.
  assign w_owner  = (r_master & ~r_casc) | (~r_master & r_cas_match);

  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_gap_nxt   = r_gap;
    w_start     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fall) begin
          w_state_nxt = S_PULSE;
          w_k_nxt     = 2'd1;
          w_gap_nxt   = '0;
          w_start     = 1'b1;
        end
      end
      S_PULSE: begin
        if (w_rise) begin
          w_state_nxt = (r_k == w_last_k) ? S_DONE : S_GAP;
        end
      end
      S_GAP: begin
        // A pulse arriving on the timeout cycle still counts.
        if (w_fall) begin
          w_state_nxt = S_PULSE;
          w_k_nxt     = r_k + 2'd1;
          w_gap_nxt   = '0;
        end else if (r_gap == GAP_LAST) begin
          w_state_nxt = S_ABORT;
          w_k_nxt     = '0;
          w_gap_nxt   = '0;
        end else begin
          w_gap_nxt   = r_gap + GAP_ONE;
        end
      end
      // Falls seen here are dropped; a new sequence needs IDLE first.
      S_DONE, S_ABORT: begin
        w_state_nxt = S_IDLE;
        w_k_nxt     = '0;
        w_gap_nxt   = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_k_nxt     = '0;
        w_gap_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // Plain sample of inta_n; not reset so a low inta_n at reset release
    // does not look like a fresh falling edge.
    r_inta_q <= inta_n;
    if (rst) begin
      r_state     <= S_IDLE;
      r_k         <= '0;
      r_gap       <= '0;
      r_master    <= 1'b0;
      r_casc      <= 1'b0;
      r_mode86    <= 1'b0;
      r_cas_match <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
      r_gap   <= w_gap_nxt;
      if (w_start) begin
        r_master    <= w_master;
        r_casc      <= w_casc;
        r_mode86    <= cfg_mode86;
        r_cas_match <= ~w_master & w_id_ok;
      end
    end
  end

  // Level is only observed while the sequence is active, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_start) begin
      r_lvl <= ack_level;
    end
  end

  always_comb begin
    cas_oe    = w_active & r_master & r_casc;
    cas_out   = cas_oe ? r_lvl : '0;
    cas_match = w_active & r_cas_match;
    seq_done  = (r_state == S_DONE);
    seq_abort = (r_state == S_ABORT);
    vec_rd_en = 1'b0;
    byte_sel  = 2'd0;
    if (r_state == S_PULSE) begin
      if (r_mode86) begin
        if ((r_k == 2'd2) && w_owner) begin
          vec_rd_en = 1'b1;
          byte_sel  = 2'd1;
        end
      end else begin
        case (r_k)
          // CALL opcode always comes from the master, cascaded or not.
          2'd1: begin
            if (r_master) begin
              vec_rd_en = 1'b1;
              byte_sel  = 2'd0;
            end
          end
          2'd2: begin
            if (w_owner) begin
              vec_rd_en = 1'b1;
              byte_sel  = 2'd1;
            end
          end
          2'd3: begin
            if (w_owner) begin
              vec_rd_en = 1'b1;
              byte_sel  = 2'd2;
            end
          end
          default: begin
            vec_rd_en = 1'b0;
            byte_sel  = 2'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cascade_sequencer.sv
module tb_cascade_sequencer;

  logic       clk;
  logic       rst;
  logic       inta_n;
  logic       sp_en_n;
  logic       buf_mode;
  logic       buf_ms;
  logic       cfg_sngl;
  logic       cfg_mode86;
  logic [7:0] cfg_slv;
  logic [2:0] slave_id;
  logic [2:0] ack_level;
  logic [2:0] cas_in;
  logic [2:0] cas_out;
  logic       cas_oe;
  logic       cas_match;
  logic       vec_rd_en;
  logic [1:0] byte_sel;
  logic       seq_done;
  logic       seq_abort;
`ifdef CAS_PARITY_EN
  logic       cas_par_out;
  logic       cas_par_in;
`endif

  int checks = 0;
  int errors = 0;

  cascade_sequencer #(
    .CAS_W   (3),
    .TIMEOUT (15)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .inta_n     (inta_n),
    .sp_en_n    (sp_en_n),
    .buf_mode   (buf_mode),
    .buf_ms     (buf_ms),
    .cfg_sngl   (cfg_sngl),
    .cfg_mode86 (cfg_mode86),
    .cfg_slv    (cfg_slv),
    .slave_id   (slave_id),
    .ack_level  (ack_level),
    .cas_in     (cas_in),
    .cas_out    (cas_out),
    .cas_oe     (cas_oe),
    .cas_match  (cas_match),
    .vec_rd_en  (vec_rd_en),
    .byte_sel   (byte_sel),
    .seq_done   (seq_done),
    .seq_abort  (seq_abort)
`ifdef CAS_PARITY_EN
    ,
    .cas_par_out(cas_par_out),
    .cas_par_in (cas_par_in)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic exp_out(input string tag, input logic e_oe, input logic [2:0] e_out,
                         input logic e_match, input logic e_vec, input logic [1:0] e_bsel,
                         input logic e_done, input logic e_abort);
    chk($sformatf("%s.cas_oe", tag),    8'(cas_oe),    8'(e_oe));
    chk($sformatf("%s.cas_out", tag),   8'(cas_out),   8'(e_out));
    chk($sformatf("%s.cas_match", tag), 8'(cas_match), 8'(e_match));
    chk($sformatf("%s.vec_rd_en", tag), 8'(vec_rd_en), 8'(e_vec));
    chk($sformatf("%s.byte_sel", tag),  8'(byte_sel),  8'(e_bsel));
    chk($sformatf("%s.seq_done", tag),  8'(seq_done),  8'(e_done));
    chk($sformatf("%s.seq_abort", tag), 8'(seq_abort), 8'(e_abort));
  endtask

  initial begin
    rst        = 1'b1;
    inta_n     = 1'b1;
    sp_en_n    = 1'b1;
    buf_mode   = 1'b0;
    buf_ms     = 1'b0;
    cfg_sngl   = 1'b0;
    cfg_mode86 = 1'b1;
    cfg_slv    = 8'h04;
    slave_id   = 3'd0;
    ack_level  = 3'd2;
    cas_in     = 3'd0;
`ifdef CAS_PARITY_EN
    cas_par_in = 1'b0;
`endif
    repeat (3) step();
    exp_out("reset", 0, 3'd0, 0, 0, 2'd0, 0, 0);
    rst = 1'b0;
    step();

    // 1: master, 8086, cascaded slave on IR2
    inta_n = 1'b0; step();
    exp_out("t1_p1", 1, 3'd2, 0, 0, 2'd0, 0, 0);
    step();
    exp_out("t1_p1b", 1, 3'd2, 0, 0, 2'd0, 0, 0);
    inta_n = 1'b1; step();
    exp_out("t1_gap", 1, 3'd2, 0, 0, 2'd0, 0, 0);
    inta_n = 1'b0; step();
    exp_out("t1_p2", 1, 3'd2, 0, 0, 2'd0, 0, 0);
    inta_n = 1'b1; step();
    exp_out("t1_done", 1, 3'd2, 0, 0, 2'd0, 1, 0);
`ifdef CAS_PARITY_EN
    chk("t1_par", 8'(cas_par_out), 8'd1);
`endif
    step();
    exp_out("t1_idle", 0, 3'd0, 0, 0, 2'd0, 0, 0);
`ifdef CAS_PARITY_EN
    chk("t1_par_idle", 8'(cas_par_out), 8'd0);
`endif

    // 2: slave, 8086, ID 5 addressed; cas_in change mid-sequence must not matter
    sp_en_n = 1'b0; slave_id = 3'd5; cas_in = 3'd5; cfg_slv = 8'h00;
    inta_n = 1'b0; step();
    exp_out("t2_p1", 0, 3'd0, 1, 0, 2'd0, 0, 0);
    inta_n = 1'b1; cas_in = 3'd4; step();
    exp_out("t2_gap", 0, 3'd0, 1, 0, 2'd0, 0, 0);
    inta_n = 1'b0; step();
    exp_out("t2_p2", 0, 3'd0, 1, 1, 2'd1, 0, 0);
    inta_n = 1'b1; step();
    exp_out("t2_done", 0, 3'd0, 1, 0, 2'd0, 1, 0);
    step();
    exp_out("t2_idle", 0, 3'd0, 0, 0, 2'd0, 0, 0);
    // slave not addressed
    cas_in = 3'd4;
    inta_n = 1'b0; step();
    exp_out("t2n_p1", 0, 3'd0, 0, 0, 2'd0, 0, 0);
    inta_n = 1'b1; step();
    inta_n = 1'b0; step();
    exp_out("t2n_p2", 0, 3'd0, 0, 0, 2'd0, 0, 0);
    inta_n = 1'b1; step();
    exp_out("t2n_done", 0, 3'd0, 0, 0, 2'd0, 1, 0);
    step();

    // 3: master, 8080, no cascade; cfg changes mid-sequence are ignored
    sp_en_n = 1'b1; cfg_mode86 = 1'b0; cfg_slv = 8'h00; ack_level = 3'd6;
    inta_n = 1'b0; step();
    exp_out("t3_p1", 0, 3'd0, 0, 1, 2'd0, 0, 0);
    cfg_mode86 = 1'b1; cfg_slv = 8'hFF;
    inta_n = 1'b1; step();
    exp_out("t3_gap1", 0, 3'd0, 0, 0, 2'd0, 0, 0);
    inta_n = 1'b0; step();
    exp_out("t3_p2", 0, 3'd0, 0, 1, 2'd1, 0, 0);
    inta_n = 1'b1; step();
    exp_out("t3_gap2", 0, 3'd0, 0, 0, 2'd0, 0, 0);
    inta_n = 1'b0; step();
    exp_out("t3_p3", 0, 3'd0, 0, 1, 2'd2, 0, 0);
    inta_n = 1'b1; step();
    exp_out("t3_done", 0, 3'd0, 0, 0, 2'd0, 1, 0);
    // fall during DONE is dropped
    inta_n = 1'b0; step();
    exp_out("t3_fall_in_done", 0, 3'd0, 0, 0, 2'd0, 0, 0);
    inta_n = 1'b1; step(); step();
    exp_out("t3_idle", 0, 3'd0, 0, 0, 2'd0, 0, 0);
    cfg_mode86 = 1'b1; cfg_slv = 8'h04; ack_level = 3'd2;

    // 4: master, 8086, gap timeout after pulse 1
    inta_n = 1'b0; step();
    exp_out("t4_p1", 1, 3'd2, 0, 0, 2'd0, 0, 0);
    inta_n = 1'b1;
    repeat (15) step();
    exp_out("t4_gap_last", 1, 3'd2, 0, 0, 2'd0, 0, 0);
    step();
    exp_out("t4_abort", 0, 3'd0, 0, 0, 2'd0, 0, 1);
    step();
    exp_out("t4_after", 0, 3'd0, 0, 0, 2'd0, 0, 0);
    inta_n = 1'b0; step();
    exp_out("t4_new_p1", 1, 3'd2, 0, 0, 2'd0, 0, 0);
    inta_n = 1'b1; step();
    exp_out("t4_new_gap", 1, 3'd2, 0, 0, 2'd0, 0, 0);
    inta_n = 1'b0; step();
    inta_n = 1'b1; step();
    exp_out("t4_new_done", 1, 3'd2, 0, 0, 2'd0, 1, 0);
    step();

    // 5: reset during pulse 2 with CAS driven
    inta_n = 1'b0; step();
    inta_n = 1'b1; step();
    inta_n = 1'b0; step();
    exp_out("t5_p2", 1, 3'd2, 0, 0, 2'd0, 0, 0);
    rst = 1'b1; step();
    exp_out("t5_rst", 0, 3'd0, 0, 0, 2'd0, 0, 0);
    rst = 1'b0; step();
    exp_out("t5_idle_low", 0, 3'd0, 0, 0, 2'd0, 0, 0);
    inta_n = 1'b1; step();
    exp_out("t5_rise_idle", 0, 3'd0, 0, 0, 2'd0, 0, 0);
    inta_n = 1'b0; step();
    exp_out("t5_new_p1", 1, 3'd2, 0, 0, 2'd0, 0, 0);
    inta_n = 1'b1; step();
    exp_out("t5_new_gap", 1, 3'd2, 0, 0, 2'd0, 0, 0);
    inta_n = 1'b0; step();
    inta_n = 1'b1; step();
    exp_out("t5_new_done", 1, 3'd2, 0, 0, 2'd0, 1, 0);
    step();

    // 6: buffered mode, role from buf_ms overrides sp_en_n
    buf_mode = 1'b1; buf_ms = 1'b0; sp_en_n = 1'b1;
    slave_id = 3'd5; cas_in = 3'd5; cfg_slv = 8'h00;
    inta_n = 1'b0; step();
    exp_out("t6_p1", 0, 3'd0, 1, 0, 2'd0, 0, 0);
    inta_n = 1'b1; step();
    inta_n = 1'b0; step();
    exp_out("t6_p2", 0, 3'd0, 1, 1, 2'd1, 0, 0);
    inta_n = 1'b1; step(); step();
    buf_ms = 1'b1; sp_en_n = 1'b0; cfg_slv = 8'h04;
    inta_n = 1'b0; step();
    exp_out("t6m_p1", 1, 3'd2, 0, 0, 2'd0, 0, 0);
    inta_n = 1'b1; step();
    inta_n = 1'b0; step();
    inta_n = 1'b1; step();
    exp_out("t6m_done", 1, 3'd2, 0, 0, 2'd0, 1, 0);
    step();
`ifdef CAS_PARITY_EN
    // right ID, bad parity: no match, no vector, sequence still completes
    buf_ms = 1'b0; cas_in = 3'd5; cas_par_in = 1'b1; cfg_slv = 8'h00;
    inta_n = 1'b0; step();
    exp_out("t6p_p1", 0, 3'd0, 0, 0, 2'd0, 0, 0);
    inta_n = 1'b1; step();
    inta_n = 1'b0; step();
    exp_out("t6p_p2", 0, 3'd0, 0, 0, 2'd0, 0, 0);
    inta_n = 1'b1; step();
    exp_out("t6p_done", 0, 3'd0, 0, 0, 2'd0, 1, 0);
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
